// File: rtl/base_obs_pkg.sv
// Shared definitions for the observation-group selector and its capture-side decoder.
// Both sides size the group index with the same rule so their encodings always match.
package base_obs_pkg;

    localparam int OBS_GROUPS_MIN = 2;

    function automatic int obs_selw(input int groups);
        return (groups <= OBS_GROUPS_MIN) ? 1 : $clog2(groups);
    endfunction

    function automatic int obs_grp_next(input int grp, input int groups);
        return (grp == groups - 1) ? 0 : grp + 1;
    endfunction

endpackage

// File: rtl/base_obs_dwell_cnt.sv
// Group sequencer: dwell counter, auto-rotation of the current group and the
// "first sample of this dwell" flag used for sticky restart and frame marking.
module base_obs_dwell_cnt
    import base_obs_pkg::*;
#(
    parameter int groups = 4,
    parameter int cntw   = 8,
    parameter int selw   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_en,
    input  logic            cfg_auto,
    input  logic [selw-1:0] cfg_sel,
    input  logic [cntw-1:0] cfg_dwell,
    output logic [selw-1:0] grp,
    output logic            first
);

    logic [cntw-1:0] cnt;

    // A lowered dwell below the running count is not guarded: cnt wraps before advancing.
    always_ff @(posedge clk) begin
        if (reset || !cfg_en) begin
            grp   <= '0;
            cnt   <= '0;
            first <= 1'b1;
        end else if (cfg_auto) begin
            if (cnt == cfg_dwell) begin
                grp   <= selw'(obs_grp_next(int'(grp), groups));
                cnt   <= '0;
                first <= 1'b1;
            end else begin
                cnt   <= cnt + cntw'(1);
                first <= 1'b0;
            end
        end else begin
            grp   <= cfg_sel;
            cnt   <= '0;
            first <= (cfg_sel != grp);
        end
    end

endmodule

// File: rtl/base_obs_select.sv
// Picks one w-bit group of the debug bus per cycle (manual or auto-rotating, with
// optional sticky OR over a dwell) and tags it with group number and frame marker.
module base_obs_select
    import base_obs_pkg::*;
#(
    parameter int   w      = 2,
    parameter int   groups = 4,
    parameter int   cntw   = 8,
    localparam int  selw   = obs_selw(groups)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [groups*w-1:0]   din,
    input  logic                  cfg_en,
    input  logic                  cfg_auto,
    input  logic                  cfg_sticky,
    input  logic [selw-1:0]       cfg_sel,
    input  logic [cntw-1:0]       cfg_dwell,
    output logic [w-1:0]          dout,
    output logic [selw-1:0]       dout_grp,
    output logic                  dout_frame
);

    logic [selw-1:0] grp;
    logic            first;
    logic [w-1:0]    sel;

    base_obs_dwell_cnt #(
        .groups (groups),
        .cntw   (cntw),
        .selw   (selw)
    ) u_dwell (
        .clk       (clk),
        .reset     (reset),
        .cfg_en    (cfg_en),
        .cfg_auto  (cfg_auto),
        .cfg_sel   (cfg_sel),
        .cfg_dwell (cfg_dwell),
        .grp       (grp),
        .first     (first)
    );

    // Group 0 occupies the most-significant w bits of din; an out-of-range index reads zero.
    always_comb begin
        sel = '0;
        for (int g = 0; g < groups; g++) begin
            if (int'(grp) == g) begin
                sel = din[(groups-1-g)*w +: w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !cfg_en) begin
            dout       <= '0;
            dout_grp   <= '0;
            dout_frame <= 1'b0;
        end else begin
            dout       <= (cfg_sticky && !first) ? (dout | sel) : sel;
            dout_grp   <= grp;
            dout_frame <= cfg_auto && first && (grp == '0);
        end
    end

endmodule

// File: tb/tb_base_obs_select.sv
// Bench for base_obs_select: directed vector table, hand-written corner sequences and
// randomized traffic compared against a dwell/rotation reference model (groups=4 and groups=3).
module tb_base_obs_select;

    typedef struct {
        int grp;
        int cnt;
        bit first;
        int dout;
        int dgrp;
        bit frame;
    } mstate_t;

    typedef struct {
        bit rst;
        bit ramp;
        int e_dout;
        int e_grp;
        int e_frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_en;
    logic       cfg_auto;
    logic       cfg_sticky;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_dwell;
    logic [1:0] gv4 [4];
    logic [1:0] gv3 [4];
    logic [7:0] din4;
    logic [5:0] din3;
    logic [1:0] dout4, dout3, grp4, grp3;
    logic       frame4, frame3;

    int checks = 0;
    int failures = 0;
    mstate_t m4, m3;
    vec_t vecs[14];

    assign din4 = {gv4[0], gv4[1], gv4[2], gv4[3]};
    assign din3 = {gv3[0], gv3[1], gv3[2]};

    always #5 clk = ~clk;

    base_obs_select #(.w(2), .groups(4), .cntw(8)) dut (
        .clk(clk), .reset(reset), .din(din4), .cfg_en(cfg_en), .cfg_auto(cfg_auto),
        .cfg_sticky(cfg_sticky), .cfg_sel(cfg_sel), .cfg_dwell(cfg_dwell),
        .dout(dout4), .dout_grp(grp4), .dout_frame(frame4)
    );

    base_obs_select #(.w(2), .groups(3), .cntw(8)) dut3 (
        .clk(clk), .reset(reset), .din(din3), .cfg_en(cfg_en), .cfg_auto(cfg_auto),
        .cfg_sticky(cfg_sticky), .cfg_sel(cfg_sel), .cfg_dwell(cfg_dwell),
        .dout(dout3), .dout_grp(grp3), .dout_frame(frame3)
    );

    function automatic mstate_t model_step(mstate_t s, int groups, logic [1:0] gv [4],
                                           bit rst, bit en, bit au, bit st, int sel_cfg, int dwell);
        mstate_t n = s;
        int selv;
        if (rst || !en) begin
            n = '{grp: 0, cnt: 0, first: 1'b1, dout: 0, dgrp: 0, frame: 1'b0};
            return n;
        end
        selv    = (s.grp < groups) ? int'(gv[s.grp]) : 0;
        n.dout  = (st && !s.first) ? (s.dout | selv) : selv;
        n.dgrp  = s.grp;
        n.frame = au && s.first && (s.grp == 0);
        if (au) begin
            if (s.cnt == dwell) begin
                n.grp   = (s.grp + 1) % groups;
                n.cnt   = 0;
                n.first = 1'b1;
            end else begin
                n.cnt   = (s.cnt + 1) % 256;
                n.first = 1'b0;
            end
        end else begin
            n.first = (sel_cfg != s.grp);
            n.grp   = sel_cfg;
            n.cnt   = 0;
        end
        return n;
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        m4 = model_step(m4, 4, gv4, reset, cfg_en, cfg_auto, cfg_sticky, int'(cfg_sel), int'(cfg_dwell));
        m3 = model_step(m3, 3, gv3, reset, cfg_en, cfg_auto, cfg_sticky, int'(cfg_sel), int'(cfg_dwell));
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_gv4(input int a, input int b, input int c, input int d);
        gv4[0] = 2'(a); gv4[1] = 2'(b); gv4[2] = 2'(c); gv4[3] = 2'(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_en = 1'b1; cfg_auto = 1'b1; cfg_sticky = 1'b0;
        cfg_sel = 2'd0; cfg_dwell = 8'd2;
        set_gv4(3, 3, 3, 3);
        for (int g = 0; g < 4; g++) gv3[g] = 2'd0;

        // Reset then auto rotation with dwell 2 over the ramp pattern 00,01,10,11.
        vecs[0]  = '{1, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 3, 0, 1};
        vecs[2]  = '{0, 1, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 1, 0};
        vecs[5]  = '{0, 1, 1, 1, 0};
        vecs[6]  = '{0, 1, 1, 1, 0};
        vecs[7]  = '{0, 1, 2, 2, 0};
        vecs[8]  = '{0, 1, 2, 2, 0};
        vecs[9]  = '{0, 1, 2, 2, 0};
        vecs[10] = '{0, 1, 3, 3, 0};
        vecs[11] = '{0, 1, 3, 3, 0};
        vecs[12] = '{0, 1, 3, 3, 0};
        vecs[13] = '{0, 1, 0, 0, 1};
        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst;
            if (vecs[i].ramp) set_gv4(0, 1, 2, 3); else set_gv4(3, 3, 3, 3);
            applyStimulus();
            checkOutput($sformatf("vec%0d_dout", i), int'(dout4), vecs[i].e_dout);
            checkOutput($sformatf("vec%0d_grp", i), int'(grp4), vecs[i].e_grp);
            checkOutput($sformatf("vec%0d_frame", i), int'(frame4), vecs[i].e_frame);
        end

        // Sticky: one-cycle pulse on group 1 bit0 in its second dwell cycle.
        cfg_dwell = 8'd3; cfg_sticky = 1'b1;
        set_gv4(0, 0, 2, 0);
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            gv4[1] = (n == 6) ? 2'd1 : 2'd0;
            applyStimulus();
            if (n == 5) checkOutput("sticky_pre_pulse", int'(dout4), 0);
            if (n >= 6 && n <= 8) begin
                checkOutput($sformatf("sticky_hold%0d", n), int'(dout4), 1);
                checkOutput($sformatf("sticky_grp%0d", n), int'(grp4), 1);
            end
            if (n == 9) begin
                checkOutput("sticky_fresh_g2", int'(dout4), 2);
                checkOutput("sticky_grp_g2", int'(grp4), 2);
            end
        end

        // Reset in the middle of a 10-cycle dwell of group 1.
        cfg_sticky = 1'b0; cfg_dwell = 8'd9;
        set_gv4(0, 3, 0, 0);
        do_reset();
        for (int n = 1; n <= 14; n++) applyStimulus();
        checkOutput("midreset_before_dout", int'(dout4), 3);
        checkOutput("midreset_before_grp", int'(grp4), 1);
        reset = 1'b1;
        applyStimulus();
        checkOutput("midreset_dout", int'(dout4), 0);
        checkOutput("midreset_grp", int'(grp4), 0);
        checkOutput("midreset_frame", int'(frame4), 0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("midreset_restart_grp", int'(grp4), 0);
        checkOutput("midreset_restart_frame", int'(frame4), 1);

        // Enable dropped for one cycle while group 2 is current.
        cfg_dwell = 8'd1;
        set_gv4(1, 2, 3, 0);
        do_reset();
        for (int n = 1; n <= 5; n++) applyStimulus();
        checkOutput("en_before_grp", int'(grp4), 2);
        cfg_en = 1'b0;
        applyStimulus();
        checkOutput("en_off_dout", int'(dout4), 0);
        checkOutput("en_off_frame", int'(frame4), 0);
        cfg_en = 1'b1;
        applyStimulus();
        checkOutput("en_resume_dout", int'(dout4), 1);
        checkOutput("en_resume_grp", int'(grp4), 0);
        checkOutput("en_resume_frame", int'(frame4), 1);

        // Manual select change 2 -> 1 with sticky on; out-of-range select on groups=3.
        cfg_auto = 1'b0; cfg_sticky = 1'b1; cfg_sel = 2'd2;
        set_gv4(0, 1, 3, 0);
        do_reset();
        for (int n = 1; n <= 3; n++) applyStimulus();
        checkOutput("manual_g2_dout", int'(dout4), 3);
        cfg_sel = 2'd1;
        applyStimulus();
        applyStimulus();
        checkOutput("manual_switch_dout", int'(dout4), 1);
        checkOutput("manual_switch_grp", int'(grp4), 1);
        checkOutput("manual_frame", int'(frame4), 0);
        for (int g = 0; g < 4; g++) gv3[g] = 2'd3;
        cfg_sel = 2'd3;
        applyStimulus();
        applyStimulus();
        checkOutput("oob_dout", int'(dout3), 0);
        checkOutput("oob_grp", int'(grp3), 3);

        // Randomized traffic against the reference model.
        cfg_auto = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit prev_auto;
            prev_auto = cfg_auto;
            reset  = ($urandom_range(0, 99) == 0);
            cfg_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0) cfg_auto = ~cfg_auto;
            if (!prev_auto && cfg_auto) cfg_en = 1'b0;
            if ($urandom_range(0, 9) == 0) cfg_sticky = ~cfg_sticky;
            if ($urandom_range(0, 3) == 0) cfg_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) cfg_dwell = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) begin
                for (int g = 0; g < 4; g++) begin
                    gv4[g] = 2'($urandom_range(0, 3));
                    gv3[g] = 2'($urandom_range(0, 3));
                end
            end
            applyStimulus();
            checkOutput("rnd4_dout", int'(dout4), m4.dout);
            checkOutput("rnd4_grp", int'(grp4), m4.dgrp);
            checkOutput("rnd4_frame", int'(frame4), int'(m4.frame));
            checkOutput("rnd3_dout", int'(dout3), m3.dout);
            checkOutput("rnd3_grp", int'(grp3), m3.dgrp);
            checkOutput("rnd3_frame", int'(frame3), int'(m3.frame));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
